// File: rtl/cpu_pkg.sv
// Shared types and default geometry for the Game & Watch CPU timebase.
package cpu_pkg;

  localparam int unsigned DIV_W_DEF  = 15;
  localparam int unsigned F1_BIT_DEF = 13;
  localparam int unsigned F4_BIT_DEF = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXEC    = 3'd3,
    LOAD_PC = 3'd4,
    HALT    = 3'd5
  } stage_t;

endpackage

// File: rtl/cpu_divider.sv
// Free-running 32.768 kHz divider with prioritised clear requests and the sticky gamma flag.
module cpu_divider
  import cpu_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divider_tick,
  input  logic             reset_divider,
  input  logic             reset_divider_keep_6,
  input  logic             reset_gamma,
  output logic [DIV_W-1:0] divider,
  output logic             gamma
);

  logic [DIV_W-1:0] divider_q, divider_d;
  logic             gamma_q, gamma_d;
  logic [DIV_W:0]   inc_full;
  logic [5:0]       low6_inc;
  logic             wrap;

  assign inc_full = {1'b0, divider_q} + {{DIV_W{1'b0}}, 1'b1};
  assign low6_inc = divider_q[5:0] + 6'd1;

  always_comb begin
    divider_d = divider_q;
    wrap      = 1'b0;
    if (reset_divider) begin
      divider_d = '0;
    end else if (reset_divider_keep_6) begin
      // Upper bits clear; the low six still count, and their carry is discarded.
      divider_d = {{(DIV_W-6){1'b0}}, (divider_tick ? low6_inc : divider_q[5:0])};
    end else if (divider_tick) begin
      divider_d = inc_full[DIV_W-1:0];
      wrap      = inc_full[DIV_W];
    end
    // A wrap outranks a coincident clear so the 1 Hz event is never lost.
    gamma_d = wrap | (gamma_q & ~reset_gamma);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divider_q <= '0;
      gamma_q   <= 1'b0;
    end else begin
      divider_q <= divider_d;
      gamma_q   <= gamma_d;
    end
  end

  assign divider = divider_q;
  assign gamma   = gamma_q;

endmodule

// File: rtl/cpu_timebase_sequencer.sv
// Timebase and instruction-stage sequencer for one Game & Watch CPU core, including CEND halt/wake.
module cpu_timebase_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned F1_BIT = F1_BIT_DEF,
  parameter int unsigned F4_BIT = F4_BIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             divider_tick,
  input  logic             cpu_tick,
  input  logic             halt_req,
  input  logic             reset_divider,
  input  logic             reset_divider_keep_6,
  input  logic             reset_gamma,
  input  logic [3:0]       input_k,
  output stage_t           stage,
  output logic [DIV_W-1:0] divider,
  output logic             divider_4hz,
  output logic             divider_32hz,
  output logic             gamma,
  output logic             halted,
  output logic             instr_done,
  output logic             overrun
);

  stage_t stage_q, stage_d;
  logic   halt_pend_q, halt_pend_d;
  logic   overrun_q, overrun_d;
  logic   instr_done_q, instr_done_d;
  logic   halted_q, halted_d;

  cpu_divider #(
    .DIV_W(DIV_W)
  ) u_divider (
    .clk                  (clk),
    .reset                (reset),
    .divider_tick         (divider_tick),
    .reset_divider        (reset_divider),
    .reset_divider_keep_6 (reset_divider_keep_6),
    .reset_gamma          (reset_gamma),
    .divider              (divider),
    .gamma                (gamma)
  );

  always_comb begin
    stage_d     = stage_q;
    halt_pend_d = 1'b0;
    overrun_d   = overrun_q;
    unique case (stage_q)
      IDLE: begin
        if (cpu_tick) stage_d = FETCH;
      end
      FETCH: begin
        stage_d = DECODE;
        if (cpu_tick) overrun_d = 1'b1;
      end
      DECODE: begin
        stage_d = EXEC;
        if (cpu_tick) overrun_d = 1'b1;
      end
      EXEC: begin
        stage_d     = LOAD_PC;
        halt_pend_d = halt_req;
        if (cpu_tick) overrun_d = 1'b1;
      end
      LOAD_PC: begin
        // A pending halt wins over a back-to-back tick.
        if (halt_pend_q)   stage_d = HALT;
        else if (cpu_tick) stage_d = FETCH;
        else               stage_d = IDLE;
      end
      HALT: begin
        if ((|input_k) || gamma) stage_d = IDLE;
      end
      default: stage_d = IDLE;
    endcase
    instr_done_d = (stage_d == LOAD_PC);
    halted_d     = (stage_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q      <= IDLE;
      halt_pend_q  <= 1'b0;
      overrun_q    <= 1'b0;
      instr_done_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      stage_q      <= stage_d;
      halt_pend_q  <= halt_pend_d;
      overrun_q    <= overrun_d;
      instr_done_q <= instr_done_d;
      halted_q     <= halted_d;
    end
  end

  assign stage        = stage_q;
  assign divider_4hz  = divider[F1_BIT];
  assign divider_32hz = divider[F4_BIT];
  assign halted       = halted_q;
  assign instr_done   = instr_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_cpu_timebase_sequencer.sv
// Bench for cpu_timebase_sequencer: stage table, divider/halt corner sequences, random vs. reference model.
module tb_cpu_timebase_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0, divider_tick = 1'b0, cpu_tick = 1'b0, halt_req = 1'b0;
  logic        reset_divider = 1'b0, reset_divider_keep_6 = 1'b0, reset_gamma = 1'b0;
  logic [3:0]  input_k = 4'b0;
  logic [2:0]  stage;
  logic [14:0] divider;
  logic        divider_4hz, divider_32hz, gamma, halted, instr_done, overrun;

  always #5 clk = ~clk;

  cpu_timebase_sequencer #(
    .DIV_W (15),
    .F1_BIT(13),
    .F4_BIT(10)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .divider_tick         (divider_tick),
    .cpu_tick             (cpu_tick),
    .halt_req             (halt_req),
    .reset_divider        (reset_divider),
    .reset_divider_keep_6 (reset_divider_keep_6),
    .reset_gamma          (reset_gamma),
    .input_k              (input_k),
    .stage                (stage),
    .divider              (divider),
    .divider_4hz          (divider_4hz),
    .divider_32hz         (divider_32hz),
    .gamma                (gamma),
    .halted               (halted),
    .instr_done           (instr_done),
    .overrun              (overrun)
  );

  int ck_total = 0;
  int ck_pass  = 0;

  // Reference model: divider as an integer count, instruction progress as a slot number 0..4.
  int m_div  = 0;
  int m_pos  = 0;
  bit m_g    = 0;
  bit m_halt = 0;
  bit m_hp   = 0;
  bit m_over = 0;

  typedef struct packed {
    logic       rst;
    logic       ct;
    logic       hr;
    logic [3:0] k;
    logic [2:0] stg;
    logic       done;
    logic       over;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    ck_total++;
    if (got === want) ck_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
  endtask

  function automatic logic [23:0] model_vec();
    logic [14:0] d;
    logic [2:0]  es;
    logic        done;
    d    = m_div[14:0];
    es   = m_halt ? 3'd5 : 3'(m_pos);
    done = !m_halt && (m_pos == 4);
    return {es, d, d[13], d[10], m_g, m_halt, done, m_over};
  endfunction

  task automatic model_update(input bit rst, dt, ct, hr, rdv, k6, rg, input logic [3:0] k);
    int nd;
    bit wrap;
    if (rst) begin
      m_div = 0; m_g = 0; m_pos = 0; m_halt = 0; m_hp = 0; m_over = 0;
      return;
    end
    wrap = 0;
    if (rdv)     nd = 0;
    else if (k6) nd = dt ? ((m_div + 1) % 64) : (m_div % 64);
    else if (dt) begin
      nd   = (m_div + 1) % 32768;
      wrap = (nd == 0);
    end else nd = m_div;
    if (m_halt) begin
      if (k != 4'b0 || m_g) m_halt = 0;
    end else begin
      case (m_pos)
        0: if (ct) m_pos = 1;
        1, 2: begin
          m_pos = m_pos + 1;
          if (ct) m_over = 1;
        end
        3: begin
          m_pos = 4;
          m_hp  = hr;
          if (ct) m_over = 1;
        end
        default: begin
          if (m_hp) begin
            m_halt = 1;
            m_pos  = 0;
          end else m_pos = ct ? 1 : 0;
          m_hp = 0;
        end
      endcase
    end
    m_g   = wrap || (m_g && !rg);
    m_div = nd;
  endtask

  task automatic step(input bit rst, dt, ct, hr, rdv, k6, rg, input logic [3:0] k);
    reset = rst; divider_tick = dt; cpu_tick = ct; halt_req = hr;
    reset_divider = rdv; reset_divider_keep_6 = k6; reset_gamma = rg; input_k = k;
    @(posedge clk);
    model_update(rst, dt, ct, hr, rdv, k6, rg, k);
    #1;
    check("model", {8'b0, stage, divider, divider_4hz, divider_32hz, gamma, halted, instr_done, overrun},
          {8'b0, model_vec()});
  endtask

  task automatic add(input logic rst, ct, hr, input logic [3:0] k, input logic [2:0] stg,
                     input logic done, over);
    vq.push_back('{rst, ct, hr, k, stg, done, over});
  endtask

  initial begin
    // rst ct hr k   -> stage done overrun   (0 IDLE,1 FETCH,2 DECODE,3 EXEC,4 LOAD_PC,5 HALT)
    add(1, 0, 0, 4'h0, 3'd0, 0, 0);
    add(0, 1, 0, 4'h0, 3'd1, 0, 0);
    add(0, 0, 0, 4'h0, 3'd2, 0, 0);
    add(0, 0, 0, 4'h0, 3'd3, 0, 0);
    add(0, 0, 0, 4'h0, 3'd4, 1, 0);
    add(0, 0, 0, 4'h0, 3'd0, 0, 0);
    add(0, 1, 0, 4'h0, 3'd1, 0, 0);
    add(0, 0, 0, 4'h0, 3'd2, 0, 0);
    add(0, 0, 0, 4'h0, 3'd3, 0, 0);
    add(0, 0, 0, 4'h0, 3'd4, 1, 0);
    add(0, 1, 0, 4'h0, 3'd1, 0, 0);   // tick on LOAD_PC: back-to-back
    add(0, 0, 0, 4'h0, 3'd2, 0, 0);
    add(0, 1, 0, 4'h0, 3'd3, 0, 1);   // tick on DECODE: dropped, overrun
    add(0, 0, 0, 4'h0, 3'd4, 1, 1);
    add(0, 0, 0, 4'h0, 3'd0, 0, 1);
    add(1, 0, 0, 4'h0, 3'd0, 0, 0);
    add(0, 1, 0, 4'h0, 3'd1, 0, 0);
    add(0, 0, 0, 4'h0, 3'd2, 0, 0);
    add(0, 0, 1, 4'h0, 3'd3, 0, 0);   // halt_req in DECODE is ignored
    add(0, 0, 0, 4'h0, 3'd4, 1, 0);
    add(0, 0, 0, 4'h0, 3'd0, 0, 0);
    add(0, 1, 0, 4'h0, 3'd1, 0, 0);
    add(0, 0, 0, 4'h0, 3'd2, 0, 0);
    add(0, 0, 0, 4'h0, 3'd3, 0, 0);
    add(0, 0, 1, 4'h0, 3'd4, 1, 0);   // halt_req in EXEC
    add(0, 0, 0, 4'h0, 3'd5, 0, 0);
    add(0, 1, 0, 4'h0, 3'd5, 0, 0);   // tick in HALT ignored, no overrun
    add(0, 0, 0, 4'h4, 3'd0, 0, 0);   // K wake
    add(0, 0, 0, 4'h0, 3'd0, 0, 0);
    add(0, 1, 0, 4'h0, 3'd1, 0, 0);
    add(0, 0, 0, 4'h0, 3'd2, 0, 0);
    add(0, 0, 0, 4'h0, 3'd3, 0, 0);
    add(1, 0, 1, 4'h0, 3'd0, 0, 0);   // reset mid-EXEC with halt_req
    add(0, 0, 0, 4'h0, 3'd0, 0, 0);

    foreach (vq[i]) begin
      step(vq[i].rst, 0, vq[i].ct, vq[i].hr, 0, 0, 0, vq[i].k);
      check("tbl_stage",  32'(stage),      32'(vq[i].stg));
      check("tbl_done",   32'(instr_done), 32'(vq[i].done));
      check("tbl_over",   32'(overrun),    32'(vq[i].over));
      check("tbl_halted", 32'(halted),     32'(vq[i].stg == 3'd5));
      check("tbl_div",    32'(divider),    32'h0);
    end

    // Divider ramp to the top value, sampling the F1/F4 taps on the way.
    for (int n = 1; n <= 32767; n++) begin
      step(0, 1, 0, 0, 0, 0, 0, 4'h0);
      if (n == 'h1FFF) begin
        check("tap4_1fff",  32'(divider_4hz),  32'h0);
        check("tap32_1fff", 32'(divider_32hz), 32'h1);
      end
      if (n == 'h2000) begin
        check("tap4_2000",  32'(divider_4hz),  32'h1);
        check("tap32_2000", 32'(divider_32hz), 32'h0);
      end
      if (n == 'h3FFF) begin
        check("tap4_3fff",  32'(divider_4hz),  32'h1);
        check("tap32_3fff", 32'(divider_32hz), 32'h1);
      end
    end
    check("div_top",   32'(divider), 32'h7FFF);
    check("gamma_top", 32'(gamma),   32'h0);

    // Halt, then wrap with a coincident reset_gamma: gamma survives and wakes the core.
    step(0, 0, 1, 0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 1, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    check("halt_entry", 32'(halted), 32'h1);
    step(0, 0, 1, 0, 0, 0, 0, 4'h0);
    check("halt_tick_stage", 32'(stage),   32'h5);
    check("halt_tick_over",  32'(overrun), 32'h0);
    step(0, 1, 0, 0, 0, 0, 1, 4'h0);
    check("wrap_div",   32'(divider), 32'h0);
    check("wrap_gamma", 32'(gamma),   32'h1);
    check("wrap_stage", 32'(stage),   32'h5);
    step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    check("gwake_stage",  32'(stage),  32'h0);
    check("gwake_halted", 32'(halted), 32'h0);

    // Wake already true on HALT entry: exactly one clk in HALT.
    step(0, 0, 1, 0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    step(0, 0, 0, 1, 0, 0, 0, 4'h0);
    step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    check("quick_halt", 32'(stage), 32'h5);
    step(0, 0, 0, 0, 0, 0, 0, 4'h0);
    check("quick_wake", 32'(stage), 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 4'h0);
    check("gamma_clr", 32'(gamma), 32'h0);

    // Clear-request priority with nonzero upper bits (0x00FC).
    for (int n = 0; n < 'hFC; n++) step(0, 1, 0, 0, 0, 0, 0, 4'h0);
    check("div_fc", 32'(divider), 32'hFC);
    step(0, 1, 0, 0, 0, 1, 0, 4'h0);
    check("keep6_tick", 32'(divider), 32'h3D);
    check("keep6_gamma", 32'(gamma), 32'h0);
    step(0, 1, 0, 0, 1, 1, 0, 4'h0);
    check("rd_all", 32'(divider), 32'h0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(63) == 0, $urandom_range(1) == 1, $urandom_range(3) == 0,
           $urandom_range(1) == 1, $urandom_range(31) == 0, $urandom_range(31) == 0,
           $urandom_range(15) == 0, ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'h0);
    end

    $display("%0d/%0d checks passed", ck_pass, ck_total);
    $finish;
  end

endmodule
